// File: rtl/adder_meas_pkg.sv
// Shared types and defaults for the ripple-adder ring measurement sequencer.
package adder_meas_pkg;

    localparam int unsigned DefaultWidth     = 32;
    localparam int unsigned DefaultWinW      = 16;
    localparam int unsigned DefaultSettleCyc = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUN     = 3'd2,
        SETTLE  = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } meas_state_t;

    typedef struct packed {
        logic [DefaultWidth-1:0] count;
        logic [DefaultWidth-1:0] sum;
        logic                    overflow;
    } meas_result_t;

endpackage

// File: rtl/meas_window_timer.sv
// Loadable down-counter; expired is high while the count is at its last cycle (<= 1).
module meas_window_timer #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Load wins over decrement; the count never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A load of N gives N enabled cycles before the owner moves on.
    assign expired_o = (cnt_q <= Width'(1));

endmodule

// File: rtl/adder_ring_meas_ctrl.sv
// Measurement sequencer: present operands, run the adder ring for a window, capture results.
module adder_ring_meas_ctrl
    import adder_meas_pkg::*;
#(
    parameter int unsigned WIDTH      = DefaultWidth,
    parameter int unsigned WIN_W      = DefaultWinW,
    parameter int unsigned SETTLE_CYC = DefaultSettleCyc
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [WIN_W-1:0] cmd_window,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             ring_en,
    output logic             cnt_clear,
    input  logic [WIDTH-1:0] ring_count,
    input  logic [WIDTH-1:0] adder_sum,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_count,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_overflow,
    output logic             busy
);

    // The result record type is sized by the package default.
    if (WIDTH != DefaultWidth) begin : g_width_check
        $error("WIDTH must equal adder_meas_pkg::DefaultWidth");
    end

    // A zero settle length would still cost one cycle in SETTLE.
    localparam logic [WIN_W-1:0] SettleLoad =
        (SETTLE_CYC == 0) ? WIN_W'(1) : WIN_W'(SETTLE_CYC);

    meas_state_t      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] ring_prev_q, ring_prev_d;
    logic             run_prev_q, run_prev_d;
    logic             ovf_q, ovf_d;
    meas_result_t     res_q, res_d;

    logic             timer_load, timer_en, timer_expired;
    logic [WIN_W-1:0] timer_load_val;

    meas_window_timer #(
        .Width (WIN_W)
    ) u_timer (
        .clk_i      (wb_clk_i),
        .rst_ni     (wb_rst_n),
        .load_i     (timer_load),
        .load_val_i (timer_load_val),
        .en_i       (timer_en),
        .expired_o  (timer_expired)
    );

    // Next-state, operand latch, timer control and result capture.
    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        res_d          = res_q;
        timer_load     = 1'b0;
        timer_load_val = '0;
        timer_en       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    a_d            = cmd_a;
                    b_d            = cmd_b;
                    timer_load     = 1'b1;
                    timer_load_val = (cmd_window == '0) ? WIN_W'(1) : cmd_window;
                    state_d        = CLEAR;
                end
            end
            CLEAR: state_d = RUN;
            RUN: begin
                timer_en = 1'b1;
                if (timer_expired) begin
                    timer_load     = 1'b1;
                    timer_load_val = SettleLoad;
                    state_d        = SETTLE;
                end
            end
            SETTLE: begin
                timer_en = 1'b1;
                if (timer_expired) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                res_d.count    = ring_count;
                res_d.sum      = adder_sum;
                res_d.overflow = ovf_q;
                state_d        = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky wrap detect; only compare RUN samples against a previous RUN sample so the
    // stale pre-clear value seen during CLEAR never looks like a wrap.
    always_comb begin
        ring_prev_d = ring_count;
        run_prev_d  = (state_q == RUN);
        ovf_d       = ovf_q;
        if (state_q == CLEAR) begin
            ovf_d = 1'b0;
        end else if ((state_q == RUN) && run_prev_q && (ring_count < ring_prev_q)) begin
            ovf_d = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            ring_prev_q <= '0;
            run_prev_q  <= 1'b0;
            ovf_q       <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ring_prev_q <= ring_prev_d;
            run_prev_q  <= run_prev_d;
            ovf_q       <= ovf_d;
            res_q       <= res_d;
        end
    end

    // Controls decode straight from the state flop so reset drops ring_en asynchronously.
    assign cmd_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign cnt_clear    = (state_q == CLEAR);
    assign ring_en      = (state_q == RUN);
    assign res_valid    = (state_q == DONE);
    assign adder_a      = a_q;
    assign adder_b      = b_q;
    assign res_count    = res_q.count;
    assign res_sum      = res_q.sum;
    assign res_overflow = res_q.overflow;

endmodule
